// File: rtl/demux16_deserializer_if.sv
// ---------------------------------------------------------------------------
// demux16_deserializer_if
//
// Bundles the serial input stream, the steering controls and the parallel
// output handshake of demux16_deserializer into one interface. The clock and
// reset are plain ports on the design and are not part of the bundle.
//
// Signals:
//   in_bit     serial data bit
//   in_valid   in_bit is valid this cycle
//   in_ready   deserializer accepts a beat this cycle (combinational)
//   addr_mode  0 = sequential counter steering, 1 = addressed steering
//   S3..S0     bit-position select used in addressed mode (S3 = MSB)
//   flush      synchronous abort of the partially assembled word
//   out_word   assembled 16-bit word (registered)
//   out_valid  out_word holds an unconsumed word
//   out_ready  consumer accepts out_word
//   beat_cnt   beats accepted toward the current word
//   par_err    parity mismatch flag, qualified by out_valid
//
// Modports:
//   slave   the deserializer itself
//   master  the environment: serial source plus parallel consumer
// ---------------------------------------------------------------------------
interface demux16_deserializer_if;

    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic        addr_mode;
    logic        S3;
    logic        S2;
    logic        S1;
    logic        S0;
    logic        flush;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  beat_cnt;
    logic        par_err;

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready,
        input  addr_mode,
        input  S3,
        input  S2,
        input  S1,
        input  S0,
        input  flush,
        output out_word,
        output out_valid,
        input  out_ready,
        output beat_cnt,
        output par_err
    );

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready,
        output addr_mode,
        output S3,
        output S2,
        output S1,
        output S0,
        output flush,
        input  out_word,
        input  out_valid,
        output out_ready,
        input  beat_cnt,
        input  par_err
    );

endinterface

// File: rtl/demux16_deserializer.sv
// ---------------------------------------------------------------------------
// demux16_deserializer
//
// Sequential 1-to-16 demultiplexer. A serial bit stream is steered into the
// 16 bit positions of an assembly register, either by an internal beat index
// (sequential mode) or by the explicit select S3..S0 (addressed mode). Once
// the word is complete it is moved into a registered valid/ready output port
// that feeds the parallel shift stages.
//
// Parameters:
//   LSB_FIRST  sequential fill order: 1 = beat k writes bit k,
//              0 = beat k writes bit 15-k
//   WORD_CLR   1 = assembly register cleared after each completed word,
//              0 = assembly register keeps its previous contents
//
// Optional build macro:
//   DEMUX_PARITY_EN  when defined each word is 17 beats, the 17th being an
//                    even-parity bit over the 16 data bits; par_err reports a
//                    mismatch alongside out_word. When undefined words are 16
//                    beats and par_err is tied to 0.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    demux16_deserializer_if.slave (stream, steering and output port)
// ---------------------------------------------------------------------------
module demux16_deserializer #(
    parameter int LSB_FIRST = 1,
    parameter int WORD_CLR  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    demux16_deserializer_if.slave       bus
);

`ifdef DEMUX_PARITY_EN
    // The 17th beat (index 16) carries parity and closes the word.
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif

    logic [4:0]  idx_q;
    logic [15:0] asm_q;
    logic [15:0] out_word_q;
    logic        out_valid_q;

    logic        in_ready;
    logic        accept;
    logic        complete;
    logic        transfer;
    logic        data_beat;
    logic [3:0]  pos;
    logic [15:0] asm_merged;

    // Only the closing beat can stall: it needs the output register, which
    // is still busy while an unconsumed word sits there. The consumer taking
    // that word in the same cycle frees the register just in time.
    assign in_ready = !((idx_q == LAST_IDX) && out_valid_q && !bus.out_ready);

    // A flush wins over any beat offered alongside it.
    assign accept   = bus.in_valid && in_ready && !bus.flush;
    assign complete = accept && (idx_q == LAST_IDX);
    assign transfer = out_valid_q && bus.out_ready;

`ifdef DEMUX_PARITY_EN
    // The parity beat ignores steering and writes no data position.
    assign data_beat = (idx_q != LAST_IDX);
`else
    assign data_beat = 1'b1;
`endif

    // Pick the bit position for this beat. Mode is sampled per beat, so the
    // steering can switch between sequential and addressed mid-word.
    always_comb begin
        pos = idx_q[3:0];
        if (bus.addr_mode) begin
            pos = {bus.S3, bus.S2, bus.S1, bus.S0};
        end else if (LSB_FIRST == 0) begin
            pos = 4'd15 - idx_q[3:0];
        end
    end

    // The assembly register with the current beat merged in. This is what
    // gets latched into out_word on the closing beat, so a word completes
    // one cycle after its last beat rather than two.
    always_comb begin
        asm_merged = asm_q;
        if (data_beat) begin
            asm_merged[pos] = bus.in_bit;
        end
    end

    // Assembly side: beat index and assembly register. Flush and reset both
    // discard the partial word; a completed word restarts the index and,
    // with WORD_CLR set, starts the next word from all zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (bus.flush) begin
            idx_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            if (complete) begin
                idx_q <= '0;
                asm_q <= (WORD_CLR != 0) ? 16'h0000 : asm_merged;
            end else begin
                idx_q <= idx_q + 5'd1;
                asm_q <= asm_merged;
            end
        end
    end

    // Output side: a completing beat always loads a fresh word and keeps
    // out_valid high, even when the previous word leaves in the same cycle.
    // Otherwise a transfer empties the register. Flush does not touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (complete) begin
            out_word_q  <= asm_merged;
            out_valid_q <= 1'b1;
        end else if (transfer) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic par_err_q;

    // Even parity: the 16 data bits XOR the parity bit must come to zero.
    // On the parity beat asm_merged equals the finished data word. The flag
    // travels with out_word and drops when the word leaves with no successor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (complete) begin
            par_err_q <= (^asm_merged) ^ bus.in_bit;
        end else if (transfer) begin
            par_err_q <= 1'b0;
        end
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_word  = out_word_q;
    assign bus.out_valid = out_valid_q;
    assign bus.beat_cnt  = idx_q;

endmodule

// File: tb/tb_demux16_deserializer.sv
// ---------------------------------------------------------------------------
// tb_demux16_deserializer
//
// Directed bench for demux16_deserializer with default parameters
// (LSB_FIRST=1, WORD_CLR=1). A table of whole-word vectors is streamed first,
// followed by hand-written sequences for addressed rewrites, output stall,
// flush, mid-word reset and (when DEMUX_PARITY_EN is defined) parity.
// ---------------------------------------------------------------------------
module tb_demux16_deserializer;

`ifdef DEMUX_PARITY_EN
    localparam int NBEATS = 17;
`else
    localparam int NBEATS = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 10 ns clock
    always #5 clk = ~clk;

    demux16_deserializer_if bus ();

    demux16_deserializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        am;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Offer one beat for exactly one clock edge, then sample 1 ns later.
    task automatic applyStimulus(input logic b, input logic am, input logic [3:0] sel);
        bus.in_bit    = b;
        bus.addr_mode = am;
        {bus.S3, bus.S2, bus.S1, bus.S0} = sel;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    // Bit carried by beat k of a word: data beats, then the parity beat.
    function automatic logic beatBit(input logic [15:0] data, input int k);
        if (k < 16) return data[k];
        return ^data;
    endfunction

    // Stream a whole word: sequential mode LSB first, or addressed mode with
    // selects running 15 down to 0.
    task automatic sendWord(input logic am, input logic [15:0] data);
        for (int k = 0; k < NBEATS; k++) begin
            if (k >= 16) applyStimulus(beatBit(data, k), 1'b0, 4'd0);
            else if (am) applyStimulus(data[15 - k], 1'b1, 4'(15 - k));
            else         applyStimulus(data[k], 1'b0, 4'd0);
        end
    endtask

    initial begin
        logic [3:0]  sels[16];
        logic        bits[16];
        logic [15:0] wordA;
        logic [15:0] wordB;

        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.addr_mode = 1'b0;
        {bus.S3, bus.S2, bus.S1, bus.S0} = 4'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{"seq_a5c3",  1'b0, 16'hA5C3, 16'hA5C3};
        vecs[1] = '{"seq_0000",  1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{"addr_8001", 1'b1, 16'h8001, 16'h8001};
        vecs[3] = '{"addr_1234", 1'b1, 16'h1234, 16'h1234};
        vecs[4] = '{"seq_ffff",  1'b0, 16'hFFFF, 16'hFFFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_word",  32'(bus.out_word),  32'd0);
        checkOutput("rst_beat_cnt",  32'(bus.beat_cnt),  32'd0);
        checkOutput("rst_par_err",   32'(bus.par_err),   32'd0);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;

        // Table-driven whole words with out_ready held high
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < NBEATS - 1; k++) begin
                if (vecs[v].am) applyStimulus(vecs[v].data[15 - k], 1'b1, 4'(15 - k));
                else            applyStimulus(vecs[v].data[k], 1'b0, 4'd0);
            end
            checkOutput({vecs[v].name, "_pre_valid"}, 32'(bus.out_valid), 32'd0);
            checkOutput({vecs[v].name, "_pre_cnt"}, 32'(bus.beat_cnt), 32'(NBEATS - 1));
            if (NBEATS > 16) applyStimulus(^vecs[v].data, 1'b0, 4'd0);
            else if (vecs[v].am) applyStimulus(vecs[v].data[0], 1'b1, 4'd0);
            else applyStimulus(vecs[v].data[15], 1'b0, 4'd0);
            checkOutput({vecs[v].name, "_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({vecs[v].name, "_word"},  32'(bus.out_word),  32'(vecs[v].exp));
            checkOutput({vecs[v].name, "_cnt"},   32'(bus.beat_cnt),  32'd0);
            checkOutput({vecs[v].name, "_perr"},  32'(bus.par_err),   32'd0);
            @(posedge clk);
            #1;
            checkOutput({vecs[v].name, "_drain"}, 32'(bus.out_valid), 32'd0);
        end

        // Addressed rewrites: bit 2 never written, bit 3 written twice.
        // The previous word was all ones, so a stale bit 2 would show.
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 12; k++) begin
                sels[k] = 4'(15 - k);
                bits[k] = (k == 0);
            end
            sels[12] = 4'd1;  bits[12] = 1'b0;
            sels[13] = 4'd0;  bits[13] = 1'b1;
            sels[14] = 4'd3;  bits[14] = (pass == 0);
            sels[15] = 4'd3;  bits[15] = (pass != 0);
            wordA = (pass == 0) ? 16'h8001 : 16'h8009;
            for (int k = 0; k < 16; k++) applyStimulus(bits[k], 1'b1, sels[k]);
            if (NBEATS > 16) applyStimulus(^wordA, 1'b0, 4'd0);
            checkOutput("addr_rewrite_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("addr_rewrite_word",  32'(bus.out_word),  32'(wordA));
            @(posedge clk);
            #1;
        end

        // Stall: word A held with out_ready low while word B streams in
        wordA = 16'h3C5A;
        wordB = 16'hC0DE;
        bus.out_ready = 1'b0;
        sendWord(1'b0, wordA);
        checkOutput("stall_a_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_a_word",  32'(bus.out_word),  32'(wordA));
        for (int k = 0; k < NBEATS - 1; k++) applyStimulus(beatBit(wordB, k), 1'b0, 4'd0);
        checkOutput("stall_cnt",      32'(bus.beat_cnt), 32'(NBEATS - 1));
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_bit   = beatBit(wordB, NBEATS - 1);
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stall_hold_word", 32'(bus.out_word), 32'(wordA));
        checkOutput("stall_hold_cnt",  32'(bus.beat_cnt), 32'(NBEATS - 1));
        bus.out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("b_no_bubble_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b_word",            32'(bus.out_word),  32'(wordB));
        checkOutput("b_cnt",             32'(bus.beat_cnt),  32'd0);
        @(posedge clk);
        #1;
        checkOutput("b_drain", 32'(bus.out_valid), 32'd0);

        // Flush after 7 beats, with a beat offered in the flush cycle
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("pre_flush_cnt", 32'(bus.beat_cnt), 32'd7);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_cnt",   32'(bus.beat_cnt),  32'd0);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        sendWord(1'b0, 16'h1234);
        checkOutput("post_flush_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("post_flush_word",  32'(bus.out_word),  32'h1234);
        @(posedge clk);
        #1;

        // Reset mid-word with a word still held in the output register
        bus.out_ready = 1'b0;
        sendWord(1'b0, 16'h5A5A);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 4'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_word",  32'(bus.out_word),  32'd0);
        checkOutput("midrst_cnt",   32'(bus.beat_cnt),  32'd0);
        checkOutput("midrst_perr",  32'(bus.par_err),   32'd0);
        // Only position 0 is written; leftover partial bits would show up
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 4'd0);
        if (NBEATS > 16) applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("post_rst_word",  32'(bus.out_word),  32'd0);
        @(posedge clk);
        #1;

`ifdef DEMUX_PARITY_EN
        // Parity: good word, then bad word; out_valid only after beat 17
        for (int k = 0; k < 16; k++) applyStimulus(beatBit(16'h0003, k), 1'b0, 4'd0);
        checkOutput("par_good_beat16_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("par_good_beat16_cnt",   32'(bus.beat_cnt),  32'd16);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("par_good_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("par_good_word",  32'(bus.out_word),  32'h0003);
        checkOutput("par_good_err",   32'(bus.par_err),   32'd0);
        for (int k = 0; k < 16; k++) applyStimulus(beatBit(16'h0007, k), 1'b0, 4'd0);
        checkOutput("par_bad_beat16_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'd0);
        checkOutput("par_bad_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("par_bad_word",  32'(bus.out_word),  32'h0007);
        checkOutput("par_bad_err",   32'(bus.par_err),   32'd1);
        @(posedge clk);
        #1;
        checkOutput("par_err_cleared", 32'(bus.par_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
